// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit scheduler.
// Opcodes and the one-hot scheduler state encoding.
package arp_pkg;

    localparam logic [15:0] ARP_REQUEST_CODE = 16'h0001;
    localparam logic [15:0] ARP_REPLY_CODE   = 16'h0002;

    localparam int IDLE_BIT      = 0;
    localparam int REPLY_REQ_BIT = 1;
    localparam int REQ_REQ_BIT   = 2;
    localparam int TX_BUSY_BIT   = 3;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        REPLY_REQ = 4'b0010,
        REQ_REQ   = 4'b0100,
        TX_BUSY   = 4'b1000
    } arp_state_e;

endpackage

// File: rtl/arp_retry_timer.sv
// Reply-wait timer and retry counter for ARP resolution.
// Wraps on expiry and advances the retry count until exhausted.
module arp_retry_timer #(
    parameter int TIMEOUT_CYCLES = 125_000_000,
    parameter int MAX_TRIES      = 3,
    parameter int TMR_W          = (TIMEOUT_CYCLES > 1) ?
                                   $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic run,
    output logic expire,
    output logic exhausted
);

    localparam int RTR_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTR_W-1:0] LAST_TRY  = RTR_W'(MAX_TRIES - 1);

    logic [TMR_W-1:0] timer;
    logic [RTR_W-1:0] retry_cnt;

    assign expire    = run && (timer == LAST_TICK);
    assign exhausted = (retry_cnt == LAST_TRY);

    // Count reply-wait cycles; a new resolution restarts everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            retry_cnt <= '0;
        end else if (start) begin
            timer     <= '0;
            retry_cnt <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (run) begin
            if (timer == LAST_TICK) begin
                timer <= '0;
                if (!exhausted) begin
                    retry_cnt <= retry_cnt + RTR_W'(1);
                end
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/arp_tx_sched.sv
// Shares the ARP tx engine between reply and resolution requests.
// Replies win; resolution retries with a timeout and holds the MAC.
module arp_tx_sched
    import arp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 125_000_000,
    parameter int MAX_TRIES      = 3,
    parameter int TMR_W          = (TIMEOUT_CYCLES > 1) ?
                                   $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    input  logic        arp_reply_req,
    output logic        arp_reply_ack,
    input  logic        arp_found,
    input  logic [31:0] arp_rec_source_ip_addr,
    input  logic [47:0] arp_rec_source_mac_addr,
    output logic        arp_tx_req,
    input  logic        arp_tx_ack,
    input  logic        arp_tx_end,
    output logic [15:0] arp_tx_op,
    output logic [31:0] arp_tx_dst_ip,
    output logic [47:0] arp_tx_dst_mac,
    output logic [47:0] dest_mac_addr,
    output logic        dest_mac_valid,
    output logic        resolve_fail
);

    arp_state_e  state;
    logic        pend;
    logic        need_tx;
    logic [31:0] tgt_ip;

    logic req_acked;
    logic found_hit;
    logic tmr_run;
    logic expire;
    logic exhausted;

    assign req_acked = state[REQ_REQ_BIT] && arp_tx_ack;
    assign found_hit = arp_found && pend &&
                       (arp_rec_source_ip_addr == tgt_ip);
    assign tmr_run   = pend && !need_tx;

    arp_retry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_TRIES      (MAX_TRIES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (resolve_req),
        .clear     (req_acked),
        .run       (tmr_run),
        .expire    (expire),
        .exhausted (exhausted)
    );

    // Tx arbitration FSM; frame fields latch on leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            arp_tx_req     <= 1'b0;
            arp_reply_ack  <= 1'b0;
            arp_tx_op      <= '0;
            arp_tx_dst_ip  <= '0;
            arp_tx_dst_mac <= '0;
        end else begin
            arp_reply_ack <= 1'b0;
            unique case (1'b1)
                state[IDLE_BIT]: begin
                    if (arp_reply_req) begin
                        state          <= REPLY_REQ;
                        arp_tx_req     <= 1'b1;
                        arp_tx_op      <= ARP_REPLY_CODE;
                        arp_tx_dst_ip  <= arp_rec_source_ip_addr;
                        arp_tx_dst_mac <= arp_rec_source_mac_addr;
                    end else if (need_tx) begin
                        state          <= REQ_REQ;
                        arp_tx_req     <= 1'b1;
                        arp_tx_op      <= ARP_REQUEST_CODE;
                        arp_tx_dst_ip  <= tgt_ip;
                        arp_tx_dst_mac <= '0;
                    end
                end
                state[REPLY_REQ_BIT]: begin
                    if (arp_tx_ack) begin
                        state         <= TX_BUSY;
                        arp_tx_req    <= 1'b0;
                        arp_reply_ack <= 1'b1;
                    end
                end
                state[REQ_REQ_BIT]: begin
                    if (arp_tx_ack) begin
                        state      <= TX_BUSY;
                        arp_tx_req <= 1'b0;
                    end
                end
                state[TX_BUSY_BIT]: begin
                    if (arp_tx_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    arp_tx_req <= 1'b0;
                end
            endcase
        end
    end

    // Resolution bookkeeping; later assignments take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend           <= 1'b0;
            need_tx        <= 1'b0;
            tgt_ip         <= '0;
            dest_mac_addr  <= '0;
            dest_mac_valid <= 1'b0;
            resolve_fail   <= 1'b0;
        end else begin
            resolve_fail <= 1'b0;
            if (req_acked) begin
                need_tx <= 1'b0;
            end
            if (found_hit) begin
                dest_mac_addr  <= arp_rec_source_mac_addr;
                dest_mac_valid <= 1'b1;
                pend           <= 1'b0;
                need_tx        <= 1'b0;
            end else if (expire) begin
                if (exhausted) begin
                    pend         <= 1'b0;
                    resolve_fail <= 1'b1;
                end else begin
                    need_tx <= 1'b1;
                end
            end
            if (resolve_req) begin
                tgt_ip         <= resolve_ip;
                pend           <= 1'b1;
                need_tx        <= 1'b1;
                dest_mac_valid <= 1'b0;
                resolve_fail   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/arp_tx_sched.md
Name: arp_tx_sched

Overview:
Schedules the single ARP transmit engine between two requesters.
- Requester 1: reply requests raised by the ARP receive path.
- Requester 2: address-resolution requests raised by the IP/UDP layer.
- For resolution it sends ARP requests, waits for a matching ARP reply with a timeout, and retries a bounded number of times.
- Holds the resolved destination MAC for the transmit datapath.

Parameters:
- TIMEOUT_CYCLES, 125_000_000: cycles to wait for a reply after each request is accepted (1 s at 125 MHz).
- MAX_TRIES, 3: total ARP request transmissions before giving up.
- TMR_W, $clog2(TIMEOUT_CYCLES): timer width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- resolve_req  in  1  pulse; start resolving resolve_ip
- resolve_ip  in  32  IP to resolve; sampled with resolve_req
- arp_reply_req  in  1  level from ARP rx; held until arp_reply_ack
- arp_reply_ack  out  1  one-cycle pulse; reply request taken
- arp_found  in  1  pulse from ARP rx; valid reply addressed to us received
- arp_rec_source_ip_addr  in  32  sender IP of last received ARP
- arp_rec_source_mac_addr  in  48  sender MAC of last received ARP
- arp_tx_req  out  1  request to ARP tx engine
- arp_tx_ack  in  1  one-cycle pulse; tx engine accepted the request
- arp_tx_end  in  1  one-cycle pulse; frame fully sent
- arp_tx_op  out  16  16'h0001 request / 16'h0002 reply
- arp_tx_dst_ip  out  32  target IP field for the frame
- arp_tx_dst_mac  out  48  target MAC field (48'd0 for requests)
- dest_mac_addr  out  48  resolved MAC
- dest_mac_valid  out  1  dest_mac_addr valid for resolve_ip
- resolve_fail  out  1  one-cycle pulse; MAX_TRIES exhausted

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low. All outputs reset to 0; state resets to IDLE; internal pend, need_tx, timer, retry_cnt and tgt_ip reset to 0.
- FSM states: IDLE, REPLY_REQ, REQ_REQ, TX_BUSY.
  - IDLE: if arp_reply_req, go to REPLY_REQ; else if need_tx, go to REQ_REQ. Reply has strict priority.
  - REPLY_REQ: on entry latch arp_tx_op=0002, dst_ip=arp_rec_source_ip_addr, dst_mac=arp_rec_source_mac_addr. On arp_tx_ack, go to TX_BUSY.
  - REQ_REQ: on entry latch op=0001, dst_ip=tgt_ip, dst_mac=0. On arp_tx_ack, go to TX_BUSY.
  - TX_BUSY: on arp_tx_end, go to IDLE.
- arp_tx_req: registered Moore output, high exactly while in REPLY_REQ or REQ_REQ. The first cycle high is one cycle after the IDLE decision. It drops the cycle after arp_tx_ack. arp_tx_op, arp_tx_dst_ip and arp_tx_dst_mac are stable from arp_tx_req rise until TX_BUSY exits.
- arp_reply_ack: high for one cycle, the cycle after arp_tx_ack in REPLY_REQ.
- Resolution control (evaluated in any state):
  - resolve_req: tgt_ip<=resolve_ip, pend=1, need_tx=1, retry_cnt=0, timer=0, dest_mac_valid=0.
  - Ack in REQ_REQ: need_tx=0, timer=0, and the timer starts counting.
  - arp_found && pend && arp_rec_source_ip_addr==tgt_ip: dest_mac_addr<=arp_rec_source_mac_addr, dest_mac_valid=1, pend=0, need_tx=0. A non-matching IP is ignored.
  - Timer runs while pend && !need_tx. At timer==TIMEOUT_CYCLES-1:
    - if retry_cnt==MAX_TRIES-1: pend=0 and resolve_fail pulses the next cycle;
    - otherwise retry_cnt++, need_tx=1, timer=0.
- Simultaneous events:
  - resolve_req and arp_found in the same cycle: resolve_req wins; dest_mac_valid ends at 0.
  - arp_found and timeout in the same cycle: found wins; no retry, no fail.
  - resolve_req during REQ_REQ or TX_BUSY: the in-flight frame keeps its latched fields. need_tx stays 1 even if the ack lands the same cycle, so a new request for the new IP follows.
  - Timeout during a reply's TX_BUSY: need_tx is set; the request is sent after returning to IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The tx engine must be reset in the same domain.

Decomposition:
- Shared package (arp_pkg): ARP_REQUEST_CODE=16'h0001, ARP_REPLY_CODE=16'h0002, and the state encoding (one-hot, 4 bits).
- One sub-module, arp_retry_timer: holds timer and retry_cnt, with inputs start/clear/run and outputs expire/exhausted.

Test Plan:
All scenarios use TIMEOUT_CYCLES=100, MAX_TRIES=3.
1. arp_reply_req=1, rec ip C0A80103, rec mac 001122334455 -> arp_tx_req next cycle with op 0002 and those dst fields. Ack -> arp_reply_ack one cycle, req low. tx_end -> IDLE.
2. resolve_req ip C0A80102 -> request op 0001, dst_mac 0. Ack, then 20 cycles later arp_found with src ip C0A80102, mac A1B2C3D4E5F6 -> dest_mac_valid=1, dest_mac_addr=A1B2C3D4E5F6, no further requests over 500 cycles.
3. No reply -> exactly 3 requests, each arp_tx_req rising 100 cycles after the previous ack (+1 IDLE cycle). resolve_fail pulses 100 cycles after the third ack; dest_mac_valid stays 0.
4. arp_reply_req and resolve_req in the same cycle -> reply frame first, then request after tx_end. arp_found with src ip C0A80109 -> ignored.
5. arp_found (matching) coincident with timer expiry -> valid=1, no retry. resolve_req during TX_BUSY of a request -> a second request is sent with the new IP.
6. Assert rst_n low during TX_BUSY -> all outputs 0 asynchronously; after release, no arp_tx_req until a new stimulus.
